// File: rtl/controle_pkg.sv
// Shared encodings for the execution sequencer: FSM states and the ledr one-hot mapping.
// The display/LCD logic imports this package so it decodes the same values.
package controle_pkg;

  // ST_INIT only lasts for the first cycle after reset, while run_mode picks RUN or STEP_WAIT.
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_IN   = 3'd3,
    ST_HALT = 3'd4
  } estado_t;

  localparam logic [3:0] LED_RUN  = 4'b0001;
  localparam logic [3:0] LED_STEP = 4'b0010;
  localparam logic [3:0] LED_IN   = 4'b0100;
  localparam logic [3:0] LED_HALT = 4'b1000;

  // One-hot LED pattern for a state; ST_INIT shows all LEDs off.
  function automatic logic [3:0] ledr_de_estado(estado_t st);
    logic [3:0] led;
    led = 4'b0000;
    case (st)
      ST_RUN:  led = LED_RUN;
      ST_STEP: led = LED_STEP;
      ST_IN:   led = LED_IN;
      ST_HALT: led = LED_HALT;
      default: led = 4'b0000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// ENTER key conditioning: 2-flop synchroniser, stable-level counter, debounced level
// and a one-cycle press pulse on the debounced 1->0 (key pushed) transition.
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enter_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised key differs from the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        // Differing while level is 1 means the key went down.
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and debounce state; idle is "released" (level high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= enter_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/controle_execucao.sv
// Execution sequencer: turns the board clock into a one-cycle cpu_tick per committed
// instruction, with free-run, single-step, IN stall and permanent HALT.
module controle_execucao
  import controle_pkg::*;
#(
  parameter int unsigned DIV_COUNT       = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter_n,
  input  logic        run_mode,
  input  logic        in_req,
  input  logic        stop,
  output logic        cpu_tick,
  output logic        in_ack,
  output logic        halted,
  output logic [3:0]  ledr,
  output logic [31:0] instr_count
);

  localparam int unsigned DW = $clog2(DIV_COUNT);
  localparam logic [DW-1:0] DivLast = DW'(DIV_COUNT - 1);

  estado_t       state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic [31:0]   count_q, count_d;
  logic          press;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .enter_n(enter_n),
    .press  (press)
  );

  // Next state, divider and tick/ack decisions; priority at a decision is stop > in_req > issue.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // Reset release counts as RUN entry, so the divider already sits at 1.
        if (run_mode) begin
          state_d = ST_RUN;
          div_d   = DW'(1);
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_mode) begin
          state_d = ST_STEP;
        end else if (div_q == DivLast) begin
          if (stop) begin
            state_d = ST_HALT;
          end else if (in_req) begin
            state_d = ST_IN;
          end else begin
            tick_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_STEP: begin
        if (press) begin
          if (stop) begin
            state_d = ST_HALT;
          end else if (in_req) begin
            state_d = ST_IN;
          end else begin
            tick_d = 1'b1;
          end
        end else if (run_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_IN: begin
        // The press that releases the IN is consumed here, never reused as a step.
        if (press) begin
          if (stop) begin
            state_d = ST_HALT;
          end else begin
            tick_d  = 1'b1;
            ack_d   = 1'b1;
            state_d = run_mode ? ST_RUN : ST_STEP;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    count_d = count_q + {31'b0, tick_d};
  end

  // State, divider and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      div_q   <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign cpu_tick    = tick_q;
  assign in_ack      = ack_q;
  assign halted      = (state_q == ST_HALT);
  assign ledr        = ledr_de_estado(state_q);
  assign instr_count = count_q;

endmodule

// File: tb/tb_controle_execucao.sv
// Bench for controle_execucao: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model of the sequencer rules.
module tb_controle_execucao;

  localparam int unsigned DivCount  = 4;
  localparam int unsigned DebCycles = 3;

  localparam int MInit = 0;
  localparam int MRun  = 1;
  localparam int MStep = 2;
  localparam int MIn   = 3;
  localparam int MHalt = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter_n;
  logic        run_mode;
  logic        in_req;
  logic        stop;
  logic        cpu_tick;
  logic        in_ack;
  logic        halted;
  logic [3:0]  ledr;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_state;
  int          m_age;
  bit          m_press;
  bit          m_level;
  bit          raw_hist[$];
  bit          m_tick;
  bit          m_ack;
  int unsigned m_count;

  controle_execucao #(
    .DIV_COUNT      (DivCount),
    .DEBOUNCE_CYCLES(DebCycles)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enter_n    (enter_n),
    .run_mode   (run_mode),
    .in_req     (in_req),
    .stop       (stop),
    .cpu_tick   (cpu_tick),
    .in_ack     (in_ack),
    .halted     (halted),
    .ledr       (ledr),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MInit;
    m_age   = 0;
    m_press = 1'b0;
    m_level = 1'b1;
    raw_hist.delete();
    m_tick  = 1'b0;
    m_ack   = 1'b0;
    m_count = 0;
  endtask

  function automatic logic [3:0] m_ledr();
    case (m_state)
      MRun:    return 4'b0001;
      MStep:   return 4'b0010;
      MIn:     return 4'b0100;
      MHalt:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // One clock edge of the reference: sequencing rules, then the key filter.
  task automatic model_edge();
    int ns;
    int nage;
    bit nt;
    bit na;
    bit flip;
    ns   = m_state;
    nage = 0;
    nt   = 1'b0;
    na   = 1'b0;
    case (m_state)
      MInit: begin
        ns   = run_mode ? MRun : MStep;
        nage = run_mode ? 1 : 0;
      end
      MRun: begin
        if (!run_mode) begin
          ns = MStep;
        end else begin
          if ((m_age % DivCount) == DivCount - 1) begin
            if (stop) ns = MHalt;
            else if (in_req) ns = MIn;
            else nt = 1'b1;
          end
          nage = m_age + 1;
        end
      end
      MStep: begin
        if (m_press) begin
          if (stop) ns = MHalt;
          else if (in_req) ns = MIn;
          else nt = 1'b1;
        end else if (run_mode) begin
          ns = MRun;
        end
      end
      MIn: begin
        if (m_press) begin
          if (stop) begin
            ns = MHalt;
          end else begin
            nt = 1'b1;
            na = 1'b1;
            ns = run_mode ? MRun : MStep;
          end
        end
      end
      default: ns = m_state;
    endcase
    // Debounced level flips once the key value seen through the two-flop delay has
    // differed from it on DebCycles consecutive edges.
    raw_hist.push_front(enter_n);
    if (raw_hist.size() > 16) void'(raw_hist.pop_back());
    flip = 1'b1;
    for (int i = 2; i < 2 + DebCycles; i++) begin
      if (i >= raw_hist.size()) flip = 1'b0;
      else if (raw_hist[i] == m_level) flip = 1'b0;
    end
    m_press = flip && m_level;
    if (flip) m_level = !m_level;
    m_state = ns;
    m_age   = nage;
    m_tick  = nt;
    m_ack   = na;
    m_count = m_count + (nt ? 1 : 0);
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      if (!reset) model_edge();
      #1;
      check("tick", {31'b0, cpu_tick}, {31'b0, m_tick});
      check("ack", {31'b0, in_ack}, {31'b0, m_ack});
      check("halted", {31'b0, halted}, {31'b0, (m_state == MHalt)});
      check("ledr", {28'b0, ledr}, {28'b0, m_ledr()});
      check("count", instr_count, m_count);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cycle(2);
    reset = 1'b0;
  endtask

  task automatic press_key(input int low, input int high);
    enter_n = 1'b0;
    cycle(low);
    enter_n = 1'b1;
    cycle(high);
  endtask

  initial begin
    int run_len;
    reset    = 1'b1;
    enter_n  = 1'b1;
    run_mode = 1'b1;
    in_req   = 1'b0;
    stop     = 1'b0;

    // Reset values and free-run: ticks every 4th cycle, 5 after 20 cycles.
    do_reset();
    check("reset_ledr", {28'b0, ledr}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    cycle(20);
    check("free_count", instr_count, 32'd5);

    // Single-step: three clean presses, then short glitches.
    run_mode = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) press_key(6, 8);
    check("step_count", instr_count, 32'd3);
    for (int p = 0; p < 3; p++) press_key(2, 4);
    check("glitch_count", instr_count, 32'd3);

    // IN stall at the first decision, released by a press.
    run_mode = 1'b1;
    in_req   = 1'b1;
    do_reset();
    cycle(8);
    check("in_wait_ledr", {28'b0, ledr}, 32'h4);
    check("in_wait_count", instr_count, 32'd0);
    enter_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      if (in_ack) break;
    end
    check("in_ack_pulse", {31'b0, in_ack}, 32'd1);
    check("in_ack_tick", {31'b0, cpu_tick}, 32'd1);
    in_req  = 1'b0;
    enter_n = 1'b1;
    cycle(3);
    check("in_gap_tick", {31'b0, cpu_tick}, 32'd0);
    cycle(1);
    check("in_next_tick", {31'b0, cpu_tick}, 32'd1);

    // Halt wins over IN; nothing leaves HALT but reset.
    stop   = 1'b1;
    in_req = 1'b1;
    do_reset();
    cycle(8);
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_ledr", {28'b0, ledr}, 32'h8);
    press_key(6, 8);
    run_mode = 1'b0;
    cycle(4);
    press_key(6, 8);
    run_mode = 1'b1;
    cycle(10);
    check("halt_count", instr_count, 32'd0);
    check("halt_stays", {28'b0, ledr}, 32'h8);

    // Reset in IN_WAIT with a partial press pending.
    stop   = 1'b0;
    in_req = 1'b1;
    do_reset();
    cycle(8);
    enter_n = 1'b0;
    cycle(2);
    reset   = 1'b1;
    enter_n = 1'b1;
    model_reset();
    cycle(1);
    check("rst_mid_tick", {31'b0, cpu_tick}, 32'd0);
    check("rst_mid_ledr", {28'b0, ledr}, 32'd0);
    reset    = 1'b0;
    in_req   = 1'b0;
    run_mode = 1'b0;
    cycle(12);
    check("rst_mid_count", instr_count, 32'd0);
    check("rst_mid_step", {28'b0, ledr}, 32'h2);

    // Mode switch 1->0 mid-count, then 0->1.
    run_mode = 1'b1;
    do_reset();
    cycle(2);
    run_mode = 1'b0;
    cycle(10);
    check("switch_no_tick", instr_count, 32'd0);
    run_mode = 1'b1;
    cycle(4);
    check("switch_early", {31'b0, cpu_tick}, 32'd0);
    cycle(1);
    check("switch_tick", {31'b0, cpu_tick}, 32'd1);

    // Randomized operation against the model.
    run_len = 3;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle(1);
        reset = 1'b0;
      end
      if (run_len == 0) begin
        enter_n = !enter_n;
        run_len = $urandom_range(1, 8);
      end
      run_len--;
      if ($urandom_range(0, 59) == 0) run_mode = !run_mode;
      if (m_tick) begin
        in_req = ($urandom_range(0, 3) == 0);
        stop   = ($urandom_range(0, 30) == 0);
      end
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
